// File: rtl/mem_access_unit.sv
// Load/store front end for a 1024x32 word RAM; sub-word stores are read-modify-write.
// Optional misalignment/reserved-size checking under MAU_MISALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

    state_t             state, state_n;
    logic [RAM_AW+1:0]  addr_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rdata_q;
    logic [31:0]        merge_q;

    logic               req_err;
    logic [1:0]         eff_size;
    logic [1:0]         off;
    logic [31:0]        shifted;
    logic [31:0]        loaded;
    logic [31:0]        merged;

`ifdef MAU_MISALIGN_CHECK_EN
    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));
    assign eff_size = size_q;
    assign off      = addr_q[1:0];
    assign resp_err = err_q;
`else
    // Reserved size behaves as word; low offset bits are masked to alignment.
    assign req_err  = 1'b0;
    assign eff_size = (size_q == 2'b11) ? 2'b10 : size_q;
    always_comb begin
        off = 2'b00;
        case (eff_size)
            2'b00:   off = addr_q[1:0];
            2'b01:   off = {addr_q[1], 1'b0};
            default: off = 2'b00;
        endcase
    end
    assign resp_err = 1'b0;
`endif

    assign shifted = ram_dout >> {off, 3'b000};

    always_comb begin
        loaded = ram_dout;
        case (eff_size)
            2'b00:   loaded = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   loaded = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: loaded = ram_dout;
        endcase
    end

    always_comb begin
        merged = merge_q;
        case (eff_size)
            2'b00: begin
                case (off)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) merged[31:16] = wdata_q[15:0];
                else        merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)          state_n = DONE;
                    else if (!req_we)     state_n = LOAD;
                    else if (req_size[1]) state_n = WRITE;
                    else                  state_n = READ;
                end
            end
            LOAD:    state_n = DONE;
            READ:    state_n = WRITE;
            WRITE:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr_q   <= req_addr[RAM_AW+1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state == LOAD) rdata_q <= loaded;
            if (state == READ) merge_q <= ram_dout;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    // Stores and errors never expose a stale load value.
    assign resp_rdata = (we_q | err_q) ? 32'd0 : rdata_q;
    assign ram_addr   = addr_q[RAM_AW+1:2];
    assign ram_we     = (state == WRITE);
    assign ram_din    = (state == WRITE) ? merged : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences,
// and randomized traffic against a byte-lane memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    int nvec = 0;
    int nfail = 0;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    mem_access_unit #(.RAM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wecnt;
        logic [31:0] din;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected behaviour from lane arithmetic; updates ref_mem for stores.
    task automatic ref_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output logic [31:0] din);
        int wi, off, nb;
        logic [31:0] w, mask, val;
        wi = int'(addr[11:2]);
        off = int'(addr[1:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
`ifdef MAU_MISALIGN_CHECK_EN
        err = (size == 2'd3) || (off % nb != 0);
`else
        err = 1'b0;
        off = off - (off % nb);
`endif
        rdata = 32'd0;
        din = 32'd0;
        lat = 2;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            w = ref_mem[wi];
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            val = (w >> (8 * off)) & mask;
            if (sgn && nb < 4 && val[8*nb-1]) val = val | ~mask;
            rdata = val;
        end else begin
            lat = (nb == 4) ? 2 : 3;
            w = ref_mem[wi];
            for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
            ref_mem[wi] = w;
            din = w;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wecnt, output logic [31:0] wdin, output logic [9:0] waddr);
        lat = 0;
        wecnt = 0;
        rdata = 32'hFFFF_FFFF;
        err = 1'bx;
        wdin = 32'd0;
        waddr = 10'd0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ram_we) begin
                wecnt++;
                wdin = ram_din;
                waddr = ram_addr;
            end
            if (resp_valid) begin
                lat = i;
                rdata = resp_rdata;
                err = resp_err;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] er, ed, ar, ad;
        logic ee, ae;
        int el, al, awc;
        logic [9:0] wa;
        ref_op(we, size, sgn, addr, wdata, er, ee, el, ed);
        do_req(we, size, sgn, addr, wdata, ar, ae, al, awc, ad, wa);
        chk({tag, "_rdata"}, ar, er);
        chk({tag, "_err"}, {31'd0, ae}, {31'd0, ee});
        chk({tag, "_lat"}, al, el);
        chk({tag, "_wecnt"}, awc, (we && !ee) ? 1 : 0);
        if (we && !ee) chk({tag, "_din"}, ad, ed);
    endtask

    initial begin
        logic [31:0] ar, ad, dr, ea, eb;
        logic ae, de;
        int al, awc, dl;
        logic [9:0] wa;
        logic [31:0] rd_q[$];
        logic prev_done, b_acc;

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        rst = 1'b0;

        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h10,   32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b1, 2'd0, 1'b0, 32'h11,   32'hCAFE0055, 32'h0,        1'b0, 3, 1, 32'hDEAD55EF});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0,        32'hDEAD55EF, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h12,   32'h1234ABCD, 32'h0,        1'b0, 3, 1, 32'hABCD55EF});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 32'h0});
`ifdef MAU_MISALIGN_CHECK_EN
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h11,   32'h7777,     32'h0,        1'b1, 1, 0, 32'h0});
        tv.push_back('{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
`else
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        32'hABCD55EF, 1'b0, 2, 0, 32'h0});
        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h11,   32'h7777,     32'h0,        1'b0, 3, 1, 32'hABCD7777});
        tv.push_back('{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'hABCD7777, 1'b0, 2, 0, 32'h0});
`endif

        for (int i = 0; i < tv.size(); i++) begin
            ref_op(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, dr, de, dl, ad);
            do_req(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata,
                   ar, ae, al, awc, ad, wa);
            chk($sformatf("tv%0d_rdata", i), ar, tv[i].rdata);
            chk($sformatf("tv%0d_err", i), {31'd0, ae}, {31'd0, tv[i].err});
            chk($sformatf("tv%0d_lat", i), al, tv[i].lat);
            chk($sformatf("tv%0d_wecnt", i), awc, tv[i].wecnt);
            if (tv[i].wecnt != 0) begin
                chk($sformatf("tv%0d_din", i), ad, tv[i].din);
                chk($sformatf("tv%0d_waddr", i), {22'd0, wa}, {20'd0, tv[i].addr[11:2]});
            end
        end

        for (int w = 0; w < 16; w++)
            run_check("init", 1'b1, 2'd2, 1'b0, 32'(w) << 2, $urandom);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'd0,
                 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            run_check("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        // Second request held on req_valid while the first is in flight.
        ref_op(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, ea, de, dl, ad);
        ref_op(1'b0, 2'd2, 1'b0, 32'h18, 32'd0, eb, de, dl, ad);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'd2;
        req_signed = 1'b0;
        req_addr = 32'h14;
        @(posedge clk);
        #1 req_addr = 32'h18;
        prev_done = 1'b0;
        b_acc = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid) rd_q.push_back(resp_rdata);
            if (req_ready && !b_acc) begin
                chk("b2b_accept_after_done", {31'd0, prev_done}, 32'd1);
                b_acc = 1'b1;
                prev_done = resp_valid;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end else begin
                prev_done = resp_valid;
            end
        end
        chk("b2b_accepted", {31'd0, b_acc}, 32'd1);
        chk("b2b_resp_count", rd_q.size(), 2);
        if (rd_q.size() >= 2) begin
            chk("b2b_first", rd_q[0], ea);
            chk("b2b_second", rd_q[1], eb);
        end

        // Reset asserted in the WRITE cycle of a word store.
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd2;
        req_addr = 32'h10;
        req_wdata = ~ref_mem[4];
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rstw_we_before", {31'd0, ram_we}, 32'd1);
        rst = 1'b1;
        #1 chk("rstw_we_drop", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        chk("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("rstw_mem_kept", mem[4], ref_mem[4]);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_no_resp_after", {31'd0, resp_valid}, 32'd0);
        run_check("post_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);

        for (int w = 0; w < 16; w++)
            chk($sformatf("final_mem%0d", w), mem[w], ref_mem[w]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the 1024x32 data RAM and drives its addr/din/WE port from a pipeline memory request.
- Handles byte, halfword and word loads with sign or zero extension.
- Sub-word stores are done as read-modify-write, because the RAM writes whole words only.
- Misaligned requests are checked and handled under a preprocessor macro (see Optional Feature).

Parameters:
- RAM_AW, 10, RAM word-address width. ram_addr = addr_q[RAM_AW+1:2]; higher address bits are ignored.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present; sampled only while req_ready=1
- req_ready  out  1  unit idle and accepting
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word data is taken from the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned or reserved-size request
- ram_addr  out  RAM_AW  word address to the RAM
- ram_din  out  32  write data to the RAM
- ram_we  out  1  RAM write enable
- ram_dout  in  32  RAM combinational read data

Behaviour:
- Byte lanes are little-endian: offset 0 = bits[7:0], offset 3 = bits[31:24]; a halfword at offset 2 = bits[31:16].
- FSM states: IDLE, LOAD, READ, WRITE, DONE.
- req_ready=1 only in IDLE.
- Accept occurs on a clock edge in IDLE with req_valid=1. On accept, addr_q, size_q, signed_q, we_q and wdata_q are latched.
- Transitions out of IDLE at accept:
  - error -> DONE
  - load -> LOAD
  - word store -> WRITE
  - byte/half store -> READ
- LOAD: ram_addr = word address. The selected lane of ram_dout is extended and registered into rdata_q. Next state DONE.
- READ: ram_dout is captured into merge_q. Next state WRITE.
- WRITE:
  - ram_we=1 for exactly this cycle.
  - ram_din = wdata_q for word stores.
  - For sub-word stores, ram_din = merge_q with the addressed lane(s) replaced by wdata_q[7:0] or wdata_q[15:0].
  - Next state DONE.
- DONE: resp_valid=1, resp_rdata=rdata_q (0 for stores and errors), resp_err as latched. Next state IDLE.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- No back-to-back accepts; a new accept happens no earlier than the cycle after DONE.
- ram_we is decoded combinationally from state and is 0 in every state except WRITE.
- ram_addr = addr_q word field in every state, including IDLE.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_din=0, all request registers=0.
- Reset mid-operation: state is forced to IDLE immediately. If reset rises during WRITE, ram_we drops combinationally, so the RAM sees no write at that edge. The request is discarded and no response is issued.
- req_valid while busy is ignored; the requester holds it until req_ready.
- Address wrap: bits above RAM_AW+1 are dropped, so addr 0x1000 aliases word 0.

Optional Feature:
- Macro: MAU_MISALIGN_CHECK_EN.
- Defined:
  - A halfword with addr[0]=1, a word with addr[1:0]!=0, or req_size=11 is an error.
  - An error goes IDLE->DONE with resp_err=1, no RAM access, and ram_we never asserts.
- Undefined:
  - No errors are generated; resp_err is tied to 0.
  - Low address bits are masked to alignment: half uses addr[1], word uses offset 0.
  - req_size=11 is treated as word.

Test Plan:
- Reset, then accept a word store of 0xDEADBEEF to addr 0x10 -> ram_we high for one cycle only, ram_addr=4, ram_din=0xDEADBEEF; resp_valid 2 cycles after accept; resp_rdata=0.
- RAM word 4 = 0xDEADBEEF, byte loads at 0x13 signed and unsigned -> resp_rdata=0xFFFFFFDE and 0x000000DE; halfword unsigned load at 0x10 -> 0x0000BEEF.
- Byte store of 0x55 to 0x11 over word 4 = 0xDEADBEEF -> READ then WRITE with ram_din=0xDEAD55EF; resp_valid 3 cycles after accept.
- MAU_MISALIGN_CHECK_EN defined, word load at 0x12 -> resp_valid and resp_err 1 cycle after accept, ram_we never asserts. Undefined, same request -> reads word 4 with resp_err=0.
- Assert rst while in WRITE of a store -> ram_we drops immediately, RAM word unchanged, no resp_valid, req_ready=1 after reset.
- Hold req_valid high across a load's busy cycles with a second request queued -> second request accepted only in the IDLE cycle after DONE; responses arrive in request order.
